striping: RTL and testbench
===========================

// Module: striping
//
// PURPOSE
//   Transmit-side lane distributor: accepts one DATA_W-bit word stream in the
//   clk_2f domain and deals accepted words alternately onto lane_0 and lane_1,
//   each with its own valid strobe. Its output is the stimulus for the
//   un-striping merger: striping -> un_stripring must give back the original
//   word order. Idle cycles (valid_in=0) do not advance the lane pointer.
//
// PARAMETERS
//   DATA_W  32  width of data_in, lane_0 and lane_1
//   CNT_W   8   width of the per-lane word counters (count_0/count_1)
//
// PORTS
//   clk_2f    in   1       single clock; all state on its rising edge
//   reset     in   1       asynchronous, active-high; clears all state
//   data_in   in   DATA_W  input word, sampled when valid_in=1
//   valid_in  in   1       data_in holds a word this cycle
//   resync    in   1       force the current/next word onto lane_0
//   lane_0    out  DATA_W  last word dealt to lane 0 (held between words)
//   lane_1    out  DATA_W  last word dealt to lane 1 (held between words)
//   valid_0   out  1       one-cycle strobe: lane_0 updated this cycle
//   valid_1   out  1       one-cycle strobe: lane_1 updated this cycle
//   count_0   out  CNT_W   words dealt to lane 0 since reset (wraps)
//   count_1   out  CNT_W   words dealt to lane 1 since reset (wraps)
//
// BEHAVIOUR
//   - Reset (async assert): lane_0=lane_1=0, valid_0=valid_1=0, count_0=count_1=0,
//     FSM=SEL_L0. Applies at once, also mid-stream; first word after release
//     always goes to lane_0.
//   - FSM, 2 states: SEL_L0, SEL_L1. Effective selector = SEL_L0 if resync=1,
//     else current state.
//   - valid_in=1, effective SEL_L0: lane_0<=data_in, valid_0<=1, count_0++,
//     next state SEL_L1.
//   - valid_in=1, effective SEL_L1: lane_1<=data_in, valid_1<=1, count_1++,
//     next state SEL_L0.
//   - valid_in=0: valid_0<=0, valid_1<=0, lanes and counters hold.
//     Next state = SEL_L0 if resync=1, else unchanged.
//   - Latency: 1 clk_2f cycle, data_in at edge N -> lane_x/valid_x after edge N.
//   - valid_0 and valid_1 are never high in the same cycle. Back-to-back
//     valid_in gives alternating strobes, no bubbles.
//   - Counters wrap modulo 2**CNT_W silently.
//   - Non-accepting lane's data and counter are never modified.
//   - All outputs registered; no combinational path from inputs to outputs.
//
// STRUCTURE
//   - Shared include striping_defs.vh: localparams SEL_L0=1'b0, SEL_L1=1'b1,
//     shared with un_stripring so both ends agree on lane-0-first order.
//   - One sub-module: striping_lane (data reg, valid strobe reg, CNT_W counter,
//     load enable), instantiated twice. FSM and steering stay in the top.
//
// TESTING
//   - 4 back-to-back words 0xA0..0xA3 after reset -> lane_0 0xA0 then 0xA2,
//     lane_1 0xA1 then 0xA3; valid_0/valid_1 alternate 1,0,1,0 / 0,1,0,1;
//     count_0=count_1=2.
//   - 0x11, 3 idle cycles, 0x22 -> 0x11 on lane_0, 0x22 on lane_1; strobes low
//     and lanes held during the gap.
//   - 0x01 (lane_0), then 0x02 with resync=1 -> 0x02 on lane_0,
//     count_0=2, count_1=0; next word 0x03 on lane_1.
//   - Reset asserted asynchronously between clock edges after 3 words ->
//     outputs 0 before the next edge; after release 0xBB on lane_0.
//   - CNT_W=4, 32 words -> count_0 and count_1 wrap to 0 on 16th word per lane.
//   - Loopback striping->un_stripring, random valid_in gaps, 1000 words ->
//     data_out sequence equals input sequence.

Source files
------------

// File: rtl/striping_pkg.sv
// Shared lane-select encoding and default widths for the striping transmitter.
// The select values set the lane-0-first order that the receive-side merger also uses.
package striping_pkg;

  typedef enum logic {
    SEL_L0 = 1'b0,
    SEL_L1 = 1'b1
  } sel_e;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/striping_lane.sv
// One output lane: holds the last word loaded, strobes valid for one cycle per
// load and counts loads modulo 2**CNT_W.
module striping_lane
  import striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic [CNT_W-1:0]  count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= load_i;
      // Data and count only move on a load; an idle lane keeps its last word.
      if (load_i) begin
        data_q  <= data_i;
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/striping.sv
// Transmit-side lane distributor: deals accepted words alternately onto lane 0
// and lane 1, with resync forcing the current or next word onto lane 0.
module striping
  import striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              resync,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic [CNT_W-1:0]  count_0,
  output logic [CNT_W-1:0]  count_1
);

  // Handshake: a word is accepted on every rising edge where valid_in=1; there
  // is no back-pressure, and each lane strobes valid for exactly the one cycle
  // after the edge that loaded it.
  sel_e state_q;
  sel_e eff_sel;
  logic load_0;
  logic load_1;

  assign eff_sel = resync ? SEL_L0 : state_q;
  assign load_0  = valid_in && (eff_sel == SEL_L0);
  assign load_1  = valid_in && (eff_sel == SEL_L1);

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q <= SEL_L0;
    end else begin
      case (state_q)
        SEL_L0: begin
          if (valid_in) state_q <= SEL_L1;
        end
        SEL_L1: begin
          // Resync takes this word onto lane 0, so lane 1 is next.
          if (valid_in)    state_q <= resync ? SEL_L1 : SEL_L0;
          else if (resync) state_q <= SEL_L0;
        end
        default: state_q <= SEL_L0;
      endcase
    end
  end

  striping_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane_0 (
    .clk_i   (clk_2f),
    .rst_i   (reset),
    .load_i  (load_0),
    .data_i  (data_in),
    .data_o  (lane_0),
    .valid_o (valid_0),
    .count_o (count_0)
  );

  striping_lane #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_lane_1 (
    .clk_i   (clk_2f),
    .rst_i   (reset),
    .load_i  (load_1),
    .data_i  (data_in),
    .data_o  (lane_1),
    .valid_o (valid_1),
    .count_o (count_1)
  );

endmodule

// File: tb/tb_striping.sv
// Directed bench for striping: alternation, idle gaps, resync, async reset,
// counter wrap and in-order reconstruction of a gapped word stream.
module tb_striping;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic              clk_2f;
  logic              reset;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              resync;
  logic [DATA_W-1:0] lane_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_0;
  logic              valid_1;
  logic [CNT_W-1:0]  count_0;
  logic [CNT_W-1:0]  count_1;

  int n_cmp;
  int n_err;
  logic [DATA_W-1:0] exp_q[$];

  striping #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_2f   (clk_2f),
    .reset    (reset),
    .data_in  (data_in),
    .valid_in (valid_in),
    .resync   (resync),
    .lane_0   (lane_0),
    .lane_1   (lane_1),
    .valid_0  (valid_0),
    .valid_1  (valid_1),
    .count_0  (count_0),
    .count_1  (count_1)
  );

  // Clock / reset
  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    resync   = 1'b0;
    data_in  = '0;
    @(posedge clk_2f);
    #1;
    reset = 1'b0;
  endtask

  // Driver: present one cycle of inputs, then land 1 time unit after the edge
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic r);
    valid_in = v;
    data_in  = d;
    resync   = r;
    @(posedge clk_2f);
    #1;
    valid_in = 1'b0;
    resync   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; resync = 1'b0; data_in = 32'hDEAD_BEEF;
    #3;
    n_cmp++; if (lane_0 !== 32'h0) begin n_err++; $display("FAIL rst_lane_0 got %h exp %h", lane_0, 32'h0); end
    n_cmp++; if (lane_1 !== 32'h0) begin n_err++; $display("FAIL rst_lane_1 got %h exp %h", lane_1, 32'h0); end
    n_cmp++; if (valid_0 !== 1'b0) begin n_err++; $display("FAIL rst_valid_0 got %b exp 0", valid_0); end
    n_cmp++; if (valid_1 !== 1'b0) begin n_err++; $display("FAIL rst_valid_1 got %b exp 0", valid_1); end
    n_cmp++; if (count_0 !== 8'd0) begin n_err++; $display("FAIL rst_count_0 got %0d exp 0", count_0); end
    n_cmp++; if (count_1 !== 8'd0) begin n_err++; $display("FAIL rst_count_1 got %0d exp 0", count_1); end
    @(posedge clk_2f); #1;
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] w [4];
    w[0] = 32'hA0; w[1] = 32'hA1; w[2] = 32'hA2; w[3] = 32'hA3;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, w[i], 1'b0);
      n_cmp++; if (valid_0 !== ((i % 2) == 0)) begin n_err++; $display("FAIL b2b_valid_0[%0d] got %b exp %b", i, valid_0, (i % 2) == 0); end
      n_cmp++; if (valid_1 !== ((i % 2) == 1)) begin n_err++; $display("FAIL b2b_valid_1[%0d] got %b exp %b", i, valid_1, (i % 2) == 1); end
      if ((i % 2) == 0) begin
        n_cmp++; if (lane_0 !== w[i]) begin n_err++; $display("FAIL b2b_lane_0[%0d] got %h exp %h", i, lane_0, w[i]); end
      end else begin
        n_cmp++; if (lane_1 !== w[i]) begin n_err++; $display("FAIL b2b_lane_1[%0d] got %h exp %h", i, lane_1, w[i]); end
        n_cmp++; if (lane_0 !== w[i-1]) begin n_err++; $display("FAIL b2b_lane_0_hold[%0d] got %h exp %h", i, lane_0, w[i-1]); end
      end
    end
    n_cmp++; if (count_0 !== 8'd2) begin n_err++; $display("FAIL b2b_count_0 got %0d exp 2", count_0); end
    n_cmp++; if (count_1 !== 8'd2) begin n_err++; $display("FAIL b2b_count_1 got %0d exp 2", count_1); end
    step(1'b0, 32'hFFFF_FFFF, 1'b0);
    n_cmp++; if ({valid_0, valid_1} !== 2'b00) begin n_err++; $display("FAIL b2b_idle_strobes got %b exp 00", {valid_0, valid_1}); end
  endtask

  task automatic test_idle_gap();
    do_reset();
    step(1'b1, 32'h11, 1'b0);
    n_cmp++; if (lane_0 !== 32'h11 || valid_0 !== 1'b1) begin n_err++; $display("FAIL gap_first got lane_0=%h v0=%b exp 11/1", lane_0, valid_0); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h5555_5555, 1'b0);
      n_cmp++; if ({valid_0, valid_1} !== 2'b00) begin n_err++; $display("FAIL gap_strobes[%0d] got %b exp 00", i, {valid_0, valid_1}); end
      n_cmp++; if (lane_0 !== 32'h11 || lane_1 !== 32'h0) begin n_err++; $display("FAIL gap_hold[%0d] got %h/%h exp 11/0", i, lane_0, lane_1); end
    end
    step(1'b1, 32'h22, 1'b0);
    n_cmp++; if (lane_1 !== 32'h22 || valid_1 !== 1'b1 || valid_0 !== 1'b0) begin n_err++; $display("FAIL gap_second got lane_1=%h v1=%b v0=%b exp 22/1/0", lane_1, valid_1, valid_0); end
    n_cmp++; if (count_0 !== 8'd1 || count_1 !== 8'd1) begin n_err++; $display("FAIL gap_counts got %0d/%0d exp 1/1", count_0, count_1); end
  endtask

  task automatic test_resync();
    do_reset();
    step(1'b1, 32'h01, 1'b0);
    step(1'b1, 32'h02, 1'b1);
    n_cmp++; if (lane_0 !== 32'h02 || valid_0 !== 1'b1 || valid_1 !== 1'b0) begin n_err++; $display("FAIL resync_lane_0 got %h v0=%b v1=%b exp 02/1/0", lane_0, valid_0, valid_1); end
    n_cmp++; if (count_0 !== 8'd2 || count_1 !== 8'd0) begin n_err++; $display("FAIL resync_counts got %0d/%0d exp 2/0", count_0, count_1); end
    n_cmp++; if (lane_1 !== 32'h0) begin n_err++; $display("FAIL resync_lane_1_untouched got %h exp 0", lane_1); end
    step(1'b1, 32'h03, 1'b0);
    n_cmp++; if (lane_1 !== 32'h03 || valid_1 !== 1'b1 || count_1 !== 8'd1) begin n_err++; $display("FAIL resync_next got lane_1=%h v1=%b c1=%0d exp 03/1/1", lane_1, valid_1, count_1); end
    // Pointer now at lane 0; advance it to lane 1 then resync while idle
    step(1'b1, 32'h04, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h05, 1'b0);
    n_cmp++; if (lane_0 !== 32'h05 || valid_0 !== 1'b1 || count_0 !== 8'd4) begin n_err++; $display("FAIL resync_idle got lane_0=%h v0=%b c0=%0d exp 05/1/4", lane_0, valid_0, count_0); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 32'hC1, 1'b0);
    step(1'b1, 32'hC2, 1'b0);
    step(1'b1, 32'hC3, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (lane_0 !== 32'h0 || lane_1 !== 32'h0) begin n_err++; $display("FAIL async_lanes got %h/%h exp 0/0", lane_0, lane_1); end
    n_cmp++; if ({valid_0, valid_1} !== 2'b00) begin n_err++; $display("FAIL async_strobes got %b exp 00", {valid_0, valid_1}); end
    n_cmp++; if (count_0 !== 8'd0 || count_1 !== 8'd0) begin n_err++; $display("FAIL async_counts got %0d/%0d exp 0/0", count_0, count_1); end
    #2;
    reset = 1'b0;
    step(1'b1, 32'hBB, 1'b0);
    n_cmp++; if (lane_0 !== 32'hBB || valid_0 !== 1'b1 || count_0 !== 8'd1) begin n_err++; $display("FAIL async_first got lane_0=%h v0=%b c0=%0d exp BB/1/1", lane_0, valid_0, count_0); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 510; i++) step(1'b1, DATA_W'(i), 1'b0);
    n_cmp++; if (count_0 !== 8'd255 || count_1 !== 8'd255) begin n_err++; $display("FAIL wrap_pre got %0d/%0d exp 255/255", count_0, count_1); end
    step(1'b1, DATA_W'(510), 1'b0);
    n_cmp++; if (count_0 !== 8'd0 || count_1 !== 8'd255) begin n_err++; $display("FAIL wrap_lane0 got %0d/%0d exp 0/255", count_0, count_1); end
    step(1'b1, DATA_W'(511), 1'b0);
    n_cmp++; if (count_0 !== 8'd0 || count_1 !== 8'd0) begin n_err++; $display("FAIL wrap_lane1 got %0d/%0d exp 0/0", count_0, count_1); end
    n_cmp++; if (lane_0 !== 32'd510 || lane_1 !== 32'd511) begin n_err++; $display("FAIL wrap_data got %0d/%0d exp 510/511", lane_0, lane_1); end
  endtask

  // Scoreboard: merge the two lane strobes back into one stream and compare order
  task automatic test_reorder();
    int gap;
    logic [DATA_W-1:0] got;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      gap = (i * 7) % 3;
      for (int g = 0; g < gap; g++) step(1'b0, 32'h0, 1'b0);
      exp_q.push_back(32'hC000_0000 + DATA_W'(i));
      step(1'b1, 32'hC000_0000 + DATA_W'(i), 1'b0);
      n_cmp++;
      if (valid_0 && valid_1) begin
        n_err++; $display("FAIL reorder_both_valid[%0d] got 11 exp one-hot", i);
      end else if (!valid_0 && !valid_1) begin
        n_err++; $display("FAIL reorder_no_valid[%0d] got 00 exp one-hot", i);
      end else begin
        got = valid_0 ? lane_0 : lane_1;
        if (got !== exp_q[0]) begin n_err++; $display("FAIL reorder_word[%0d] got %h exp %h", i, got, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL reorder_leftover got %0d exp 0", exp_q.size()); end
    n_cmp++; if (count_0 !== 8'd20 || count_1 !== 8'd20) begin n_err++; $display("FAIL reorder_counts got %0d/%0d exp 20/20", count_0, count_1); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; valid_in = 1'b0; resync = 1'b0; data_in = '0;
    test_reset();
    test_back_to_back();
    test_idle_gap();
    test_resync();
    test_async_reset();
    test_wrap();
    test_reorder();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
